// File: rtl/reg_bank_rst.sv
// Register bank with bit-level ops, one-deep shadow for interrupt context
// save/restore, per-register even parity with a sticky error flag and fault injection.
module reg_bank_rst #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 2,
  parameter int BIT_W   = 3,
  parameter int RST_VAL = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              write_en,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BIT_W-1:0]  bit_sel,
  input  logic [WIDTH-1:0]  data_in,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  data_out,
  input  logic              shadow_save,
  input  logic              shadow_restore,
  input  logic              inject_en,
  input  logic [WIDTH-1:0]  inject_mask,
  input  logic              err_clr,
  output logic              parity_err,
  output logic [DEPTH-1:0]  err_vec
);

  typedef enum logic [1:0] {OP_LOAD, OP_SET, OP_CLR, OP_TGL} op_e;

  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] r_value     [DEPTH];
  logic             r_parity    [DEPTH];
  logic [WIDTH-1:0] r_sh_value  [DEPTH];
  logic             r_sh_parity [DEPTH];
  logic             r_parity_err;

  logic             w_addr_ok;
  logic             w_bit_ok;
  logic             w_wr_hit;
  op_e              w_op;
  logic [WIDTH-1:0] w_wr_value;
  logic [WIDTH-1:0] w_next_value;
  logic             w_wr_parity;

  assign w_op      = op_e'(op);
  assign w_addr_ok = int'(addr) < DEPTH;
  assign w_bit_ok  = int'(bit_sel) < WIDTH;
  // Out-of-range bit ops leave both value and parity untouched, so they are not writes.
  assign w_wr_hit  = write_en && w_addr_ok && (w_op == OP_LOAD || w_bit_ok);

  assign data_out   = (int'(rd_addr) < DEPTH) ? r_value[rd_addr] : '0;
  assign parity_err = r_parity_err;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_wr_value = w_addr_ok ? r_value[addr] : '0;
    if (w_wr_hit) begin
      case (w_op)
        OP_LOAD: w_wr_value          = data_in;
        OP_SET:  w_wr_value[bit_sel] = 1'b1;
        OP_CLR:  w_wr_value[bit_sel] = 1'b0;
        OP_TGL:  w_wr_value[bit_sel] = ~w_wr_value[bit_sel];
        default: w_wr_value          = data_in;
      endcase
    end
    w_wr_parity  = ^w_wr_value;
    // Injection lands on top of any same-cycle write but never touches parity.
    w_next_value = w_wr_value ^ (inject_en ? inject_mask : '0);
  end

  always_comb begin
    err_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      err_vec[i] = (^r_value[i]) != r_parity[i];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: the bank and shadow are flops, not RAM, and must all reset to a known
      // value so parity starts consistent; do not strip this loop to save reset fan-out.
      for (int i = 0; i < DEPTH; i++) begin
        r_value[i]     <= RST_V;
        r_parity[i]    <= ^RST_V;
        r_sh_value[i]  <= RST_V;
        r_sh_parity[i] <= ^RST_V;
      end
      r_parity_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make save and restore read pre-edge state,
      // which is what lets a simultaneous save+restore swap bank and shadow.
      if (|err_vec) begin
        r_parity_err <= 1'b1;
      end else if (err_clr) begin
        r_parity_err <= 1'b0;
      end

      if (shadow_save) begin
        for (int i = 0; i < DEPTH; i++) begin
          r_sh_value[i]  <= r_value[i];
          r_sh_parity[i] <= r_parity[i];
        end
      end

      if (shadow_restore) begin
        for (int i = 0; i < DEPTH; i++) begin
          r_value[i]  <= r_sh_value[i];
          r_parity[i] <= r_sh_parity[i];
        end
      end else if (w_addr_ok && (w_wr_hit || inject_en)) begin
        r_value[addr] <= w_next_value;
        if (w_wr_hit) begin
          r_parity[addr] <= w_wr_parity;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_bank_rst.sv
// Self-checking bench for reg_bank_rst: an array-level model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_reg_bank_rst;

  logic       clock;
  logic       reset;
  logic       write_en;
  logic [1:0] op;
  logic [1:0] addr;
  logic [2:0] bit_sel;
  logic [7:0] data_in;
  logic [1:0] rd_addr;
  logic [7:0] data_out;
  logic       shadow_save;
  logic       shadow_restore;
  logic       inject_en;
  logic [7:0] inject_mask;
  logic       err_clr;
  logic       parity_err;
  logic [3:0] err_vec;

  int n_pass  = 0;
  int n_total = 0;
  bit started = 0;

  reg_bank_rst #(.WIDTH(8), .DEPTH(4), .ADDR_W(2), .BIT_W(3), .RST_VAL(1)) dut (
    .clock(clock), .reset(reset), .write_en(write_en), .op(op), .addr(addr),
    .bit_sel(bit_sel), .data_in(data_in), .rd_addr(rd_addr), .data_out(data_out),
    .shadow_save(shadow_save), .shadow_restore(shadow_restore),
    .inject_en(inject_en), .inject_mask(inject_mask), .err_clr(err_clr),
    .parity_err(parity_err), .err_vec(err_vec)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Behavioural model: whole-bank arrays updated from the rules at each edge.
  logic [7:0] m_val [4];
  logic       m_par [4];
  logic [7:0] m_sh_val [4];
  logic       m_sh_par [4];
  logic       m_err;
  logic [7:0] ov [4];
  logic       opar [4];
  logic [7:0] osv [4];
  logic       osp [4];
  logic [7:0] v;
  logic [7:0] bm;
  bit         any;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        m_val[i] = 8'h01; m_par[i] = 1'b1; m_sh_val[i] = 8'h01; m_sh_par[i] = 1'b1;
      end
      m_err = 1'b0;
    end else begin
      any = 0;
      for (int i = 0; i < 4; i++) if ((^m_val[i]) != m_par[i]) any = 1;
      if (any) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      ov = m_val; opar = m_par; osv = m_sh_val; osp = m_sh_par;
      if (shadow_save) begin m_sh_val = ov; m_sh_par = opar; end
      if (shadow_restore) begin
        m_val = osv; m_par = osp;
      end else begin
        v  = ov[addr];
        bm = 8'h01 << bit_sel;
        if (write_en) begin
          case (op)
            2'd0: v = data_in;
            2'd1: v = v | bm;
            2'd2: v = v & ~bm;
            default: v = v ^ bm;
          endcase
          m_par[addr] = ^v;
        end
        if (inject_en) v = v ^ inject_mask;
        m_val[addr] = v;
      end
    end
  end

  function automatic logic [3:0] model_err_vec();
    logic [3:0] e = '0;
    for (int i = 0; i < 4; i++) e[i] = (^m_val[i]) != m_par[i];
    return e;
  endfunction

  always @(negedge clock) begin
    if (started) begin
      check("cmp_data_out", data_out, m_val[rd_addr]);
      check("cmp_err_vec", err_vec, model_err_vec());
      check("cmp_parity_err", parity_err, m_err);
    end
  end

  task automatic idle_inputs();
    write_en = 0; op = 0; addr = 0; bit_sel = 0; data_in = 0;
    shadow_save = 0; shadow_restore = 0; inject_en = 0; inject_mask = 0; err_clr = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
    idle_inputs();
  endtask

  task automatic wr(input logic [1:0] a, input logic [1:0] o, input logic [2:0] b,
                    input logic [7:0] d);
    write_en = 1; addr = a; op = o; bit_sel = b; data_in = d;
    tick();
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string name);
    rd_addr = a;
    #1;
    check(name, data_out, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rd_addr = 0;
    reset = 1'b1;
    #1 reset = 1'b0;
    started = 1;
    #2;
    for (int i = 0; i < 4; i++) rd(2'(i), 8'h01, "reset_read");
    check("reset_err_vec", err_vec, 4'b0000);
    check("reset_parity_err", parity_err, 1'b0);
    @(posedge clock); #2 reset = 1'b1;
    tick();

    // Load and bit ops on addr 2
    wr(2, 2'd0, 0, 8'hA5); rd(2, 8'hA5, "load_a5");
    wr(2, 2'd1, 1, 8'h00); rd(2, 8'hA7, "set_bit1");
    wr(2, 2'd2, 0, 8'h00); rd(2, 8'hA6, "clr_bit0");
    wr(2, 2'd3, 7, 8'h00); rd(2, 8'h26, "tgl_bit7");

    // Odd-popcount injection creates a parity error
    inject_en = 1; addr = 1; inject_mask = 8'h04; tick();
    check("inj_err_vec", err_vec, 4'b0010);
    rd(1, 8'h05, "inj_value");
    check("inj_flag_not_yet", parity_err, 1'b0);
    tick();
    check("inj_flag_set", parity_err, 1'b1);
    err_clr = 1; tick();
    check("clr_while_err", parity_err, 1'b1);
    wr(1, 2'd0, 0, 8'h10);
    check("reload_err_vec", err_vec, 4'b0000);
    err_clr = 1; tick();
    check("clr_after_fix", parity_err, 1'b0);

    // Even-popcount injection is invisible to parity
    inject_en = 1; addr = 0; inject_mask = 8'h03; tick();
    rd(0, 8'h02, "inj_even_value");
    check("inj_even_err_vec", err_vec, 4'b0000);
    tick();
    check("inj_even_flag", parity_err, 1'b0);

    // Shadow save ignores same-cycle write; restore brings values back
    wr(0, 2'd0, 0, 8'h11); wr(1, 2'd0, 0, 8'h22);
    wr(2, 2'd0, 0, 8'h33); wr(3, 2'd0, 0, 8'h44);
    shadow_save = 1; write_en = 1; addr = 0; op = 2'd0; data_in = 8'hFF; tick();
    rd(0, 8'hFF, "save_wr_lands");
    for (int i = 0; i < 4; i++) wr(2'(i), 2'd0, 0, 8'h00);
    rd(3, 8'h00, "overwrite_zero");
    shadow_restore = 1; tick();
    rd(0, 8'h11, "restore_0"); rd(1, 8'h22, "restore_1");
    rd(2, 8'h33, "restore_2"); rd(3, 8'h44, "restore_3");

    // Simultaneous save and restore swaps bank and shadow
    for (int i = 0; i < 4; i++) wr(2'(i), 2'd0, 0, 8'h02);
    shadow_save = 1; tick();
    for (int i = 0; i < 4; i++) wr(2'(i), 2'd0, 0, 8'h01);
    shadow_save = 1; shadow_restore = 1; write_en = 1; addr = 1; data_in = 8'hEE; tick();
    for (int i = 0; i < 4; i++) rd(2'(i), 8'h02, "swap_bank");
    shadow_restore = 1; tick();
    for (int i = 0; i < 4; i++) rd(2'(i), 8'h01, "swap_shadow");

    // Asynchronous reset mid-sequence discards shadow, error and pending write
    wr(0, 2'd0, 0, 8'h77);
    shadow_save = 1; tick();
    inject_en = 1; addr = 1; inject_mask = 8'h01; tick();
    tick();
    check("pre_reset_flag", parity_err, 1'b1);
    write_en = 1; addr = 3; op = 2'd0; data_in = 8'hAA; rd_addr = 0;
    #1 reset = 1'b0;
    #1;
    check("async_reset_value", data_out, 8'h01);
    check("async_reset_flag", parity_err, 1'b0);
    check("async_reset_err_vec", err_vec, 4'b0000);
    @(posedge clock); #2 reset = 1'b1;
    idle_inputs();
    rd(3, 8'h01, "reset_drops_write");
    shadow_restore = 1; tick();
    rd(0, 8'h01, "reset_clears_shadow");
    tick();

    @(negedge clock);
    started = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reg_bank_rst.md
Name: reg_bank_rst

Overview:
- Parametrised bank of DEPTH registers, each WIDTH bits wide, for the structural PIC datapath.
- Every register resets to a common RST_VAL.
- Per-register operations: full load, bit set, bit clear and bit toggle (BSF/BCF-style).
- Adds a one-deep shadow copy of the whole bank for interrupt context save/restore.
- Stores a per-register even-parity bit with a sticky error flag, and a fault-injection port for bit-flip campaigns.

Parameters:
- WIDTH, 8, data width of each register.
- DEPTH, 4, number of registers.
- ADDR_W, 2, address width; DEPTH <= 2^ADDR_W.
- BIT_W, 3, bit-select width; WIDTH <= 2^BIT_W.
- RST_VAL, 1, reset value of every register and shadow entry, truncated to WIDTH.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- write_en  in  1  perform op on register addr this cycle.
- op  in  2  00 load data_in, 01 set bit, 10 clear bit, 11 toggle bit.
- addr  in  ADDR_W  write/op/inject target.
- bit_sel  in  BIT_W  bit index for ops 01/10/11.
- data_in  in  WIDTH  load data for op 00.
- rd_addr  in  ADDR_W  read address.
- data_out  out  WIDTH  combinational read of register rd_addr.
- shadow_save  in  1  copy whole bank (value and parity) into shadow.
- shadow_restore  in  1  copy shadow back into bank.
- inject_en  in  1  XOR inject_mask into register addr without updating its parity.
- inject_mask  in  WIDTH  bit-flip mask.
- err_clr  in  1  clear parity_err.
- parity_err  out  1  sticky: some register's stored parity mismatches its value.
- err_vec  out  DEPTH  combinational per-register mismatch, bit i for register i.

Behaviour:
- Reset (reset==0, asynchronous): all value[i] = RST_VAL, parity[i] = ^RST_VAL; shadow entries identical; parity_err = 0. While reset is low, data_out = RST_VAL for valid rd_addr and err_vec = 0.
- data_out = value[rd_addr], zero latency. rd_addr >= DEPTH returns 0.
- Write (write_en==1, addr < DEPTH), at the rising edge:
  - op 00: value <= data_in.
  - op 01: value[bit_sel] <= 1.
  - op 10: value[bit_sel] <= 0.
  - op 11: value[bit_sel] <= ~value[bit_sel].
  - On every write, parity[addr] <= ^(new value).
  - For ops 01/10/11 with bit_sel >= WIDTH: no change to value or parity.
  - addr >= DEPTH: write ignored.
- Injection (inject_en==1, addr < DEPTH): value[addr] <= (result after any same-cycle write) ^ inject_mask. parity[addr] takes the write-derived parity if write_en is also asserted, otherwise it is unchanged. A mask of odd popcount therefore produces a mismatch.
- err_vec[i] = (^value[i]) != parity[i].
- parity_err at each edge:
  - Set if |err_vec is true (evaluated on pre-edge state).
  - Else cleared if err_clr.
  - Else holds.
  - Set wins over err_clr in the same cycle.
  - A mismatch created by an edge is flagged one cycle later.
- Shadow:
  - shadow_save: shadow[i] <= value[i] and parity[i] for all i, using pre-edge values, so a same-cycle write is not captured.
  - shadow_restore: value[i]/parity[i] <= shadow[i] for all i; takes priority over write_en and inject_en (both ignored that cycle).
  - Save and restore in the same cycle swap bank and shadow.
- Shadow contents are not parity-checked; corruption shows only after restore.
- No other state. A reset mid-operation discards any pending write, shadow data and error.

Test Plan:
- Reset, then read all rd_addr 0..3 -> data_out = 8'h01, parity_err = 0, err_vec = 0. rd_addr beyond DEPTH (only when 2^ADDR_W > DEPTH) -> 0.
- Load 8'hA5 to addr 2, then op 01 bit 1, op 10 bit 0, op 11 bit 7 -> reads 8'hA5, 8'hA7, 8'hA6, 8'h26. op 01 with bit_sel >= WIDTH (when BIT_W allows it) -> unchanged.
- Inject mask 8'h04 on addr 1 -> next cycle err_vec = 4'b0010, data_out(1) = 8'h05. Following edge -> parity_err = 1. err_clr while mismatch persists -> parity_err stays 1. Reload addr 1 with 8'h10, then err_clr -> parity_err = 0.
- Inject mask 8'h03 (even popcount) on addr 0 -> data_out = 8'h02, err_vec = 0, parity_err stays 0.
- Load regs to 11/22/33/44, shadow_save with a same-cycle write 8'hFF to addr 0, then overwrite all to 0, then shadow_restore -> bank reads 11/22/33/44.
- Assert save and restore together with bank = 1s and shadow = 2s -> bank reads 2s, shadow holds 1s (verify with a second restore). Assert reset mid-sequence -> all RST_VAL immediately, asynchronously.
